// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue/write-back shell.
//   - ALU function-code constants understood by the registered 64-bit ALU
//   - is_supported_op(): true for codes the ALU actually implements
//   - ALU_LATENCY: cycles from operand registers to the ALU's Z register
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_EQ  = 4'b0110;
    localparam logic [3:0] ALU_LT  = 4'b1001;
    localparam logic [3:0] ALU_SRL = 4'b1100;
    localparam logic [3:0] ALU_NE  = 4'b1101;

    localparam int ALU_LATENCY = 1;

    // Any code outside this set makes the ALU produce an undefined Z.
    function automatic logic is_supported_op(input logic [3:0] aluctrl);
        logic ok;
        case (aluctrl)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
            ALU_EQ, ALU_LT, ALU_SRL, ALU_NE: ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
// First-word-fall-through FIFO holding completed ALU results.
// Ports:
//   CLK, RST_N       clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data  write one entry
//   pop              remove the head entry (ignored while empty)
//   head_data        current head entry, zero while empty
//   empty            no entries stored
//   count            number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // A push is allowed into a full FIFO only when the head leaves in the
    // same cycle; a pop of an empty FIFO is dropped.
    always_comb begin
        do_pop   = pop & (count_q != '0);
        do_push  = push & ((count_q != CNT_W'(DEPTH)) | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_issue_wb.sv
// ---------------------------------------------------------------------------
// alu_issue_wb
// Operand-issue and result-capture shell around the registered 64-bit ALU.
// An op accepted on the in_* handshake is registered onto alu_*; one cycle
// later the ALU registers Z; on the following edge Z and the op's tag land in
// a result FIFO presented on out_*. Issue-to-out_valid latency is 2 cycles,
// throughput one op per cycle.
// Ports:
//   CLK, RST_N                 clock, asynchronous active-low reset
//   in_valid/in_ready          op handshake
//   in_a, in_b, in_shamt,
//   in_aluctrl, in_tag         op operands, function code, destination tag
//   alu_a, alu_b, alu_shamt,
//   alu_aluctrl                registered operands driven into the ALU
//   alu_z                      ALU registered result
//   out_valid/out_ready        result handshake (FIFO head)
//   out_data, out_tag, out_err head result, its tag, unsupported-code flag
// Build option:
//   ALU_OPCHECK_EN  when defined, unsupported function codes are flagged at
//                   issue; their result is stored as 0 with out_err = 1.
//                   When undefined, alu_z is stored as-is and out_err is 0.
// ---------------------------------------------------------------------------
module alu_issue_wb
    import alu_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [5:0]        in_shamt,
    input  logic [3:0]        in_aluctrl,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [5:0]        alu_shamt,
    output logic [3:0]        alu_aluctrl,
    input  logic [DATA_W-1:0] alu_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = DATA_W + TAG_W + 1;

    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [5:0]        alu_shamt_q, alu_shamt_d;
    logic [3:0]        alu_aluctrl_q, alu_aluctrl_d;

    logic              v1_q, v1_d;
    logic              v2_q, v2_d;
    logic [TAG_W-1:0]  tag1_q, tag1_d;
    logic [TAG_W-1:0]  tag2_q, tag2_d;
    logic              err1_q, err1_d;
    logic              err2_q, err2_d;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic               fifo_push;
    logic               fifo_pop;
    logic [DATA_W-1:0]  wr_z;
    logic [CNT_W:0]     credit_sum;
    logic               issue_fire;
    logic               head_err;

    // Every accepted op owns a FIFO slot from issue onward: ops in the two
    // pipeline stages plus stored results must stay below the depth, so the
    // write two cycles later always finds room. Only registered state is used.
    always_comb begin
        credit_sum = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(v1_q) + (CNT_W+1)'(v2_q);
        in_ready   = RST_N & (credit_sum < (CNT_W+1)'(FIFO_DEPTH));
        issue_fire = in_valid & in_ready;
    end

    // Issue stage: operands hold when nothing is accepted so the ALU inputs
    // stay quiet; the tag and opcode check ride alongside in stage 1.
    always_comb begin
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_shamt_d   = alu_shamt_q;
        alu_aluctrl_d = alu_aluctrl_q;
        v1_d          = 1'b0;
        tag1_d        = tag1_q;
        err1_d        = 1'b0;
        if (issue_fire) begin
            alu_a_d       = in_a;
            alu_b_d       = in_b;
            alu_shamt_d   = in_shamt;
            alu_aluctrl_d = in_aluctrl;
            v1_d          = 1'b1;
            tag1_d        = in_tag;
`ifdef ALU_OPCHECK_EN
            err1_d        = ~is_supported_op(in_aluctrl);
`endif
        end
    end

    // Stage 2 mirrors the ALU's own output register so tag and Z line up.
    always_comb begin
        v2_d   = v1_q;
        tag2_d = tag1_q;
        err2_d = err1_q;
    end

    // Capture: an unsupported op's Z is undefined, so it is replaced by zero
    // when the check is built in.
    always_comb begin
`ifdef ALU_OPCHECK_EN
        wr_z = err2_q ? '0 : alu_z;
`else
        wr_z = alu_z;
`endif
        fifo_push  = v2_q;
        fifo_wdata = {wr_z, tag2_q, err2_q};
        fifo_pop   = out_ready & ~fifo_empty;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_shamt_q   <= '0;
            alu_aluctrl_q <= '0;
            v1_q          <= 1'b0;
            v2_q          <= 1'b0;
            tag1_q        <= '0;
            tag2_q        <= '0;
            err1_q        <= 1'b0;
            err2_q        <= 1'b0;
        end else begin
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_shamt_q   <= alu_shamt_d;
            alu_aluctrl_q <= alu_aluctrl_d;
            v1_q          <= v1_d;
            v2_q          <= v2_d;
            tag1_q        <= tag1_d;
            tag2_q        <= tag2_d;
            err1_q        <= err1_d;
            err2_q        <= err2_d;
        end
    end

    alu_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_shamt   = alu_shamt_q;
    assign alu_aluctrl = alu_aluctrl_q;

    // Without the opcode check the stored error bit is always written as 0,
    // so out_err is constant zero in that build.
    assign out_valid = ~fifo_empty;
    assign {out_data, out_tag, head_err} = fifo_head;
    assign out_err   = head_err;

endmodule

// File: tb/tb_alu_issue_wb.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_wb
// Drives alu_issue_wb with directed and random ops, emulates the registered
// ALU on alu_z, and compares every cycle against a queue-based model of
// in-order results with a fixed 2-cycle latency and a 4-slot credit limit.
// Build option ALU_OPCHECK_EN adds unsupported-code traffic.
// ---------------------------------------------------------------------------
module tb_alu_issue_wb;
    import alu_pkg::*;

    localparam int DATA_W = 64;
    localparam int TAG_W  = 5;
    localparam int DEPTH  = 4;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_a = '0;
    logic [DATA_W-1:0] in_b = '0;
    logic [5:0]        in_shamt = '0;
    logic [3:0]        in_aluctrl = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [5:0]        alu_shamt;
    logic [3:0]        alu_aluctrl;
    logic [DATA_W-1:0] alu_z = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    int compare_count  = 0;
    int mismatch_count = 0;
    int cyc            = 0;
    int dut_accepted   = 0;

    // Model state: results owed to the consumer, in issue order.
    logic [DATA_W-1:0] q_data[$];
    logic [TAG_W-1:0]  q_tag[$];
    logic              q_err[$];
    int                q_avail[$];
    logic [DATA_W-1:0] last_a = '0;
    logic [DATA_W-1:0] last_b = '0;
    logic [9:0]        last_ctrl = '0;

    logic [3:0] legal_ops [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                                  4'b0110, 4'b1001, 4'b1100, 4'b1101};
    logic [3:0] bad_ops [7] = '{4'b0101, 4'b0111, 4'b1000, 4'b1010, 4'b1011,
                                4'b1110, 4'b1111};

    alu_issue_wb #(
        .DATA_W     (DATA_W),
        .TAG_W      (TAG_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_shamt    (in_shamt),
        .in_aluctrl  (in_aluctrl),
        .in_tag      (in_tag),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_shamt   (alu_shamt),
        .alu_aluctrl (alu_aluctrl),
        .alu_z       (alu_z),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .out_err     (out_err)
    );

    always #5 CLK = ~CLK;

    // Behavioural ALU; unsupported codes return a junk pattern standing in for X.
    function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input logic [5:0] sh);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return a ^ b;
            4'b0110: return {63'd0, a == b};
            4'b1001: return {63'd0, $signed(a) < $signed(b)};
            4'b1100: return a >> sh;
            4'b1101: return {63'd0, a != b};
            default: return 64'hBAD0_BAD0_BAD0_BAD0;
        endcase
    endfunction

    always @(posedge CLK) alu_z <= alu_fn(alu_aluctrl, alu_a, alu_b, alu_shamt);

    function automatic logic is_legal(input logic [3:0] op);
        for (int i = 0; i < 9; i++) begin
            if (legal_ops[i] == op) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic applyStimulus(input logic valid, input logic [3:0] op,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [5:0] sh, input logic [4:0] tag,
                                 input logic ordy);
        logic exp_ready;
        logic exp_ovalid;
        logic fire;
        logic pop;
        logic err;
        in_valid   = valid;
        in_aluctrl = op;
        in_a       = a;
        in_b       = b;
        in_shamt   = sh;
        in_tag     = tag;
        out_ready  = ordy;
        @(negedge CLK);
        exp_ready  = RST_N && (q_data.size() < DEPTH);
        exp_ovalid = (q_data.size() > 0) && (q_avail[0] <= cyc);
        checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
        checkOutput("out_valid", 64'(out_valid), 64'(exp_ovalid));
        if (exp_ovalid) begin
            checkOutput("out_data", out_data, q_data[0]);
            checkOutput("out_tag", 64'(out_tag), 64'(q_tag[0]));
            checkOutput("out_err", 64'(out_err), 64'(q_err[0]));
        end
        checkOutput("alu_a", alu_a, last_a);
        checkOutput("alu_b", alu_b, last_b);
        checkOutput("alu_shamt_ctrl", 64'({alu_shamt, alu_aluctrl}), 64'(last_ctrl));
        if (valid && in_ready) dut_accepted++;
        fire = valid && exp_ready;
        pop  = exp_ovalid && ordy;
        @(posedge CLK);
        cyc++;
        if (pop) begin
            void'(q_data.pop_front());
            void'(q_tag.pop_front());
            void'(q_err.pop_front());
            void'(q_avail.pop_front());
        end
        if (fire) begin
`ifdef ALU_OPCHECK_EN
            err = !is_legal(op);
`else
            err = 1'b0;
`endif
            q_data.push_back(err ? 64'd0 : alu_fn(op, a, b, sh));
            q_tag.push_back(tag);
            q_err.push_back(err);
            q_avail.push_back(cyc + 1 + ALU_LATENCY);
            last_a    = a;
            last_b    = b;
            last_ctrl = {sh, op};
        end
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 64'd0, 64'd0, 6'd0, 5'd0, ordy);
    endtask

    // Asynchronous reset a little after an edge; everything owed is discarded.
    task automatic applyReset();
        RST_N    = 1'b0;
        in_valid = 1'b0;
        q_data.delete();
        q_tag.delete();
        q_err.delete();
        q_avail.delete();
        last_a    = '0;
        last_b    = '0;
        last_ctrl = '0;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_data", out_data, 64'd0);
        checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
        checkOutput("rst_out_err", 64'(out_err), 64'd0);
        checkOutput("rst_alu_a", alu_a, 64'd0);
        checkOutput("rst_alu_b", alu_b, 64'd0);
        checkOutput("rst_alu_ctrl", 64'({alu_shamt, alu_aluctrl}), 64'd0);
        @(posedge CLK);
        cyc++;
        @(posedge CLK);
        cyc++;
        #1;
        RST_N = 1'b1;
        #1;
    endtask

    initial begin
        logic [3:0] op;
        int n;
        #2;
        applyReset();

        // Single ADD, explicit look at the result two edges after issue.
        applyStimulus(1'b1, ALU_ADD, 64'd5, 64'd7, 6'd0, 5'd3, 1'b1);
        idle(2, 1'b1);
        checkOutput("add_valid", 64'(out_valid), 64'd1);
        checkOutput("add_data", out_data, 64'd12);
        checkOutput("add_tag", 64'(out_tag), 64'd3);
        idle(2, 1'b1);

        // Back-to-back SUB stream.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, ALU_SUB, 64'd10, 64'(i), 6'd0, 5'(i), 1'b1);
        end
        idle(4, 1'b1);

        // Compare and shift corner cases.
        applyStimulus(1'b1, ALU_EQ, 64'd9, 64'd9, 6'd0, 5'd1, 1'b1);
        applyStimulus(1'b1, ALU_LT, 64'd2, 64'd1, 6'd0, 5'd2, 1'b1);
        applyStimulus(1'b1, ALU_SRL, 64'h8000_0000_0000_0000, 64'd0, 6'd63, 5'd4, 1'b1);
        applyStimulus(1'b1, ALU_NE, 64'd4, 64'd4, 6'd0, 5'd5, 1'b1);
        idle(4, 1'b1);

        // Backpressure: stalled consumer, ops held until accepted.
        dut_accepted = 0;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, ALU_ADD, 64'(100 + n), 64'd1, 6'd0, 5'(10 + n), 1'b0);
            if (q_data.size() > n) n++;
        end
        checkOutput("bp_accepted", 64'(dut_accepted), 64'd4);
        applyStimulus(1'b0, ALU_ADD, 64'd0, 64'd0, 6'd0, 5'd0, 1'b1);
        applyStimulus(1'b1, ALU_ADD, 64'(100 + n), 64'd1, 6'd0, 5'(10 + n), 1'b0);
        checkOutput("bp_reaccepted", 64'(dut_accepted), 64'd5);
        idle(8, 1'b1);

`ifdef ALU_OPCHECK_EN
        // Unsupported code then a normal ADD.
        applyStimulus(1'b1, 4'b0111, 64'd3, 64'd4, 6'd0, 5'd9, 1'b1);
        applyStimulus(1'b1, ALU_ADD, 64'd3, 64'd4, 6'd0, 5'd10, 1'b1);
        idle(1, 1'b1);
        checkOutput("opchk_data", out_data, 64'd0);
        checkOutput("opchk_err", 64'(out_err), 64'd1);
        checkOutput("opchk_tag", 64'(out_tag), 64'd9);
        idle(3, 1'b1);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            op = legal_ops[$urandom_range(0, 8)];
`ifdef ALU_OPCHECK_EN
            if ($urandom_range(0, 7) == 0) op = bad_ops[$urandom_range(0, 6)];
`endif
            applyStimulus($urandom_range(0, 3) != 0, op,
                          {$urandom, $urandom}, {$urandom, $urandom},
                          6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)),
                          $urandom_range(0, 3) != 0);
        end
        idle(8, 1'b1);

        // Reset while three results are in flight or buffered.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, ALU_OR, 64'(i), 64'h100, 6'd0, 5'(20 + i), 1'b0);
        end
        idle(1, 1'b0);
        applyReset();
        idle(6, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
